musical_score_recorder: RTL and testbench

//  Writer-side counterpart of the song ROM loader. Captures notes played by the user on a fixed

---
 rtl/musical_score_recorder.sv | 145 ++++++++++++++
 tb/tb_musical_score_recorder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/musical_score_recorder.sv
// Records one 4-bit note code per beat into a song RAM while a take is running.
// Latency: the note captured over a beat is written in the cycle after the beat's last cycle.
// Backpressure: none. The RAM write port must accept wr_en_o in every cycle it is asserted.
// Build option RECORDER_MAJORITY_EN: the most frequent note in each beat is written instead of the last one.
module musical_score_recorder #(
  parameter int BEAT_CYCLES = 32_500_000,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [3:0]        note_in_i,
  input  logic              note_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [3:0]        wr_data_o,
  output logic              recording_o,
  output logic              done_o,
  output logic [ADDR_W:0]   length_o
);

  localparam int                CNT_W     = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic              wr_en_q;
  logic [3:0]        wr_data_q;
  logic              beat_end, enter_rec, sample;
  logic [3:0]        cap_note;

  assign beat_end  = (state_q == S_REC) && (beat_cnt_q == BEAT_LAST);
  assign sample    = (state_q == S_REC) && note_valid_i;
  assign enter_rec = (state_q != S_REC) && (state_d == S_REC);

  // Next state: start opens a take; stop or the final beat closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_REC;
      S_REC:          if (stop_i || (beat_end && addr_q == ADDR_LAST)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Beat counter runs only while staying in REC and parks at zero otherwise.
  always_comb begin
    beat_cnt_d = '0;
    if (state_q == S_REC && state_d == S_REC && !beat_end) beat_cnt_d = beat_cnt_q + CNT_ONE;
  end

`ifdef RECORDER_MAJORITY_EN
  logic [7:0] cnt_q   [16];
  logic [7:0] cnt_inc [16];
  logic [7:0] best;

  // Per-note histogram including this cycle's sample, saturating at 255.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (sample && note_in_i == 4'(i) && cnt_q[i] != 8'hFF) cnt_inc[i] = cnt_q[i] + 8'd1;
    end
  end

  // Argmax over the histogram; strict compare keeps the lowest code on ties.
  always_comb begin
    cap_note = 4'h0;
    best     = cnt_inc[0];
    for (int i = 1; i < 16; i++) begin
      if (cnt_inc[i] > best) begin
        best     = cnt_inc[i];
        cap_note = 4'(i);
      end
    end
  end

  // Histogram restarts at every beat boundary and at the start of a take.
  always_ff @(posedge clk) begin
    if (reset || enter_rec || beat_end) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_inc[i];
    end
  end
`else
  logic [3:0] cap_q, cap_d;

  // Last valid note of the beat, with the beat-end cycle's own sample taking precedence.
  always_comb begin
    cap_note = note_valid_i ? note_in_i : cap_q;
    cap_d    = cap_q;
    if (enter_rec || beat_end) cap_d = 4'h0;
    else if (sample)           cap_d = note_in_i;
  end

  // Capture register; cleared means the beat is a rest so far.
  always_ff @(posedge clk) begin
    if (reset) cap_q <= 4'h0;
    else       cap_q <= cap_d;
  end
`endif

  // State, beat timing, the delayed write strobe and the address/length bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 4'h0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wr_en_q    <= beat_end;
      if (beat_end) wr_data_q <= cap_note;
      if (enter_rec) begin
        addr_q <= '0;
        len_q  <= '0;
      end else if (wr_en_q) begin
        len_q <= len_q + LEN_ONE;
        // The last entry's address is held so the pointer never wraps.
        if (addr_q != ADDR_LAST) addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = wr_en_q ? wr_data_q : 4'h0;
  assign recording_o = (state_q == S_REC);
  assign done_o      = (state_q == S_DONE);
  assign length_o    = len_q;

endmodule

// File: tb/tb_musical_score_recorder.sv
// Bench for musical_score_recorder with a short beat and a small RAM.
// A beat-level reference model predicts every output each cycle; directed takes pin literal results.
// Random start/stop/reset/note traffic follows the directed takes.
module tb_musical_score_recorder;

  localparam int BC     = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0, stop = 1'b0;
  logic [3:0]        note_in = 4'h0;
  logic              note_valid = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              recording, done;
  logic [ADDR_W:0]   length;

  musical_score_recorder #(.BEAT_CYCLES(BC), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop),
    .note_in_i(note_in), .note_valid_i(note_valid),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .recording_o(recording), .done_o(done), .length_o(length)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Note chosen for a beat from the list of valid samples seen in it.
  function automatic int pick(input int q[$]);
    int res;
`ifdef RECORDER_MAJORITY_EN
    int cnt[16];
    foreach (cnt[n]) cnt[n] = 0;
    foreach (q[k]) if (cnt[q[k]] < 255) cnt[q[k]]++;
    res = 0;
    for (int n = 1; n < 16; n++) if (cnt[n] > cnt[res]) res = n;
`else
    res = (q.size() == 0) ? 0 : q[q.size()-1];
`endif
    return res;
  endfunction

  // Reference model: mode 0 idle, 1 recording, 2 done.
  int m_mode = 0, m_phase = 0, m_addr = 0, m_len = 0, m_data = 0, m_next_data = 0;
  bit m_wr = 0, m_wr_next = 0, m_last = 0, armed = 0;
  int m_samp[$];

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_phase = 0; m_addr = 0; m_len = 0; m_wr = 0; m_data = 0;
      m_samp.delete();
      armed = 1;
    end else begin
      m_wr_next = 0;
      m_last    = 0;
      if (m_mode == 1) begin
        if (note_valid) m_samp.push_back(int'(note_in));
        if (m_phase == BC - 1) begin
          m_wr_next   = 1;
          m_next_data = pick(m_samp);
          m_samp.delete();
          m_phase = 0;
          m_last  = (m_addr == DEPTH - 1);
        end else begin
          m_phase++;
        end
      end
      if (m_wr) begin
        m_len++;
        if (m_addr != DEPTH - 1) m_addr++;
      end
      if (m_mode == 1) begin
        if (stop || m_last) begin
          m_mode = 2; m_phase = 0; m_samp.delete();
        end
      end else if (start) begin
        m_mode = 1; m_addr = 0; m_len = 0; m_phase = 0; m_samp.delete();
      end
      m_wr = m_wr_next;
      if (m_wr_next) m_data = m_next_data;
    end
  end

  // Observed writes, for the directed literal checks.
  int log_a[$], log_d[$], log_dn[$];

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("wr_en", int'(wr_en), int'(m_wr));
      chk("wr_addr", int'(wr_addr), m_addr);
      if (m_wr) chk("wr_data", int'(wr_data), m_data);
      chk("recording", int'(recording), int'(m_mode == 1));
      chk("done", int'(done), int'(m_mode == 2));
      chk("length", int'(length), m_len);
    end
    if (wr_en === 1'b1) begin
      log_a.push_back(int'(wr_addr));
      log_d.push_back(int'(wr_data));
      log_dn.push_back(int'(done));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_dn.delete();
  endtask

  task automatic begin_take();
    clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic end_take();
    note_valid = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  task automatic play_beat(input int a, input int b, input int c);
    int s[3];
    s[0] = a; s[1] = b; s[2] = c;
    for (int k = 0; k < 3; k++) begin
      note_valid = (s[k] >= 0);
      note_in    = (s[k] >= 0) ? 4'(s[k]) : 4'h0;
      cyc();
    end
    note_valid = 1'b0;
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    settle();
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_length", int'(length), 0);
    chk("reset_recording", int'(recording), 0);
    reset = 1'b0;

    // Four beats of note 5.
    begin_take();
    note_valid = 1'b1; note_in = 4'd5;
    repeat (16) cyc();
    end_take();
    settle();
    chk("t1_writes", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      chk("t1_addr", log_a[i], i);
      chk("t1_data", log_d[i], 5);
    end
    chk("t1_length", int'(length), 4);

    // A silent beat writes a rest.
    begin_take();
    repeat (5) cyc();
    end_take();
    settle();
    chk("t2_writes", log_a.size(), 1);
    if (log_a.size() > 0) chk("t2_rest", log_d[0], 0);
    chk("t2_length", int'(length), 1);

    // Full take: auto-stop after entry 7.
    begin_take();
    note_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      note_in = 4'($urandom_range(0, 15));
      cyc();
    end
    note_valid = 1'b0;
    settle();
    chk("t3_writes", log_a.size(), 8);
    if (log_a.size() == 8) begin
      chk("t3_last_addr", log_a[7], 7);
      chk("t3_done_with_last", log_dn[7], 1);
      chk("t3_done_before_last", log_dn[6], 0);
    end
    chk("t3_length", int'(length), 8);
    chk("t3_recording", int'(recording), 0);
    chk("t3_addr_held", int'(wr_addr), 7);

    // Stop in beat cycle 1 after two writes.
    begin_take();
    note_valid = 1'b1; note_in = 4'd9;
    repeat (9) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    note_valid = 1'b0;
    repeat (6) cyc();
    settle();
    chk("t4_writes", log_a.size(), 2);
    chk("t4_length", int'(length), 2);
    chk("t4_done", int'(done), 1);

    // Stop in the beat-end cycle: that beat still lands.
    begin_take();
    note_valid = 1'b1; note_in = 4'd9;
    repeat (11) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    note_valid = 1'b0;
    repeat (6) cyc();
    settle();
    chk("t5_writes", log_a.size(), 3);
    chk("t5_length", int'(length), 3);

    // Reset mid-take, then a fresh take starts at address 0.
    begin_take();
    note_valid = 1'b1; note_in = 4'd2;
    repeat (6) cyc();
    reset = 1'b1; cyc();
    settle();
    chk("t6_wr_en", int'(wr_en), 0);
    chk("t6_addr", int'(wr_addr), 0);
    chk("t6_data", int'(wr_data), 0);
    chk("t6_recording", int'(recording), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_length", int'(length), 0);
    reset = 1'b0;
    begin_take();
    repeat (5) cyc();
    settle();
    chk("t6_writes", log_a.size(), 1);
    if (log_a.size() > 0) begin
      chk("t6_first_addr", log_a[0], 0);
      chk("t6_first_data", log_d[0], 2);
    end
    end_take();

    // Note selection within a single beat.
    begin_take();
`ifdef RECORDER_MAJORITY_EN
    play_beat(3, 3, 7);
`else
    play_beat(7, 3, 3);
`endif
    settle();
    chk("t7_writes", log_a.size(), 1);
    if (log_a.size() > 0) chk("t7_pick", log_d[0], 3);
    end_take();
`ifdef RECORDER_MAJORITY_EN
    begin_take();
    play_beat(3, 7, -1);
    settle();
    chk("t8_writes", log_a.size(), 1);
    if (log_a.size() > 0) chk("t8_tie", log_d[0], 3);
    end_take();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 399) == 0);
      start      = ($urandom_range(0, 29) == 0);
      stop       = ($urandom_range(0, 79) == 0);
      note_valid = ($urandom_range(0, 2) != 0);
      note_in    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      cyc();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; note_valid = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
